// File: rtl/regfile_snapshot.sv
// regfile_snapshot
// Debug snapshot reader for the unicycle core's register file. A start
// request walks register addresses 0..NUM_REGS-1 over one read port. Each
// value is captured and then streamed out as an address/data beat over a
// valid/ready handshake.
//
// Optional feature: define SNAPSHOT_CHECKSUM_EN to append a checksum beat.
// That beat carries the modulo-2^DATA_W sum of all captured values and
// asserts out_sum.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   start           level request, sampled only while idle
//   busy            high whenever a snapshot is in progress
//   done            one-cycle pulse after the final beat is accepted
//   rf_read_addr    register-file read address (equals idx)
//   rf_read_data    combinational read data for rf_read_addr
//   out_valid       beat available
//   out_ready       sink accepts the beat
//   out_data        captured register value (or checksum)
//   out_addr        register index of the current beat
//   out_last        final beat of the snapshot
//   out_sum         checksum beat marker (SNAPSHOT_CHECKSUM_EN only)
module regfile_snapshot #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
`ifdef SNAPSHOT_CHECKSUM_EN
  output logic              out_sum,
`endif
  output logic              out_last
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic              at_last;
  logic              handshake;

  assign at_last      = (idx == LAST_IDX);
  assign handshake    = out_valid && out_ready;
  assign rf_read_addr = idx;

`ifdef SNAPSHOT_CHECKSUM_EN
  // sum_phase marks the extra READ/SEND pass that emits the checksum instead
  // of a register, so the four-state walk is reused for the trailing beat.
  logic              sum_phase, sum_phase_nxt;
  logic [DATA_W-1:0] sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
`ifdef SNAPSHOT_CHECKSUM_EN
      sum_phase <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
`ifdef SNAPSHOT_CHECKSUM_EN
      sum_phase <= sum_phase_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    busy      = (state != IDLE);
    done      = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
`ifdef SNAPSHOT_CHECKSUM_EN
    sum_phase_nxt = sum_phase;
    out_sum       = 1'b0;
`endif
    case (state)
      IDLE: begin
        idx_nxt = '0;
        if (start) begin
          state_nxt = READ;
`ifdef SNAPSHOT_CHECKSUM_EN
          sum_phase_nxt = 1'b0;
`endif
        end
      end
      READ: begin
        state_nxt = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
`ifdef SNAPSHOT_CHECKSUM_EN
        out_last = sum_phase;
        out_sum  = sum_phase;
        if (handshake) begin
          if (sum_phase) begin
            state_nxt = DONE;
          end else if (at_last) begin
            sum_phase_nxt = 1'b1;
            state_nxt     = READ;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = READ;
          end
        end
`else
        out_last = at_last;
        if (handshake) begin
          if (at_last) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = READ;
          end
        end
`endif
      end
      DONE: begin
        done      = 1'b1;
        idx_nxt   = '0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Capture path: out_data/out_addr only change on READ edges, which keeps
  // them stable for the whole SEND stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
      out_addr <= '0;
`ifdef SNAPSHOT_CHECKSUM_EN
      sum <= '0;
`endif
    end else begin
`ifdef SNAPSHOT_CHECKSUM_EN
      if (state == IDLE && start) begin
        sum <= '0;
      end
      if (state == READ) begin
        if (sum_phase) begin
          out_data <= sum;
          out_addr <= '0;
        end else begin
          out_data <= rf_read_data;
          out_addr <= idx;
          sum      <= sum + rf_read_data;
        end
      end
`else
      if (state == READ) begin
        out_data <= rf_read_data;
        out_addr <= idx;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_snapshot.sv
module tb_regfile_snapshot;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;
`ifdef SNAPSHOT_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif
  // start cycle + READ/SEND per beat + DONE cycle
  localparam int DONE_CYC = 1 + 2 * (NUM_REGS + CSUM);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              busy, done;
  logic [ADDR_W-1:0] rf_read_addr;
  logic [DATA_W-1:0] rf_read_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;
  logic              out_sum_w;

  regfile_snapshot #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_REGS(NUM_REGS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .rf_read_addr(rf_read_addr),
    .rf_read_data(rf_read_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_addr    (out_addr),
`ifdef SNAPSHOT_CHECKSUM_EN
    .out_sum     (out_sum_w),
`endif
    .out_last    (out_last)
  );

`ifndef SNAPSHOT_CHECKSUM_EN
  assign out_sum_w = 1'b0;
`endif

  always #5 clk = ~clk;

  // Register-file model; r0 always reads as zero.
  logic [DATA_W-1:0] rf [NUM_REGS];
  assign rf_read_data = rf[rf_read_addr];

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              last;
    logic              sum;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    beats = 0;
  int    done_cnt = 0;
  int    ready_mode = 0;
  beat_t held;
  logic  have_hold = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beat stream for one snapshot of the current rf contents.
  task automatic push_snapshot();
    int unsigned s = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      exp_q.push_back({ADDR_W'(i), rf[i], (CSUM == 0) && (i == NUM_REGS - 1), 1'b0});
      s += rf[i];
    end
    if (CSUM != 0) exp_q.push_back({ADDR_W'(0), s[DATA_W-1:0], 1'b1, 1'b1});
  endtask

  task automatic monitor();
    beat_t cur, e;
    forever begin
      @(negedge clk);
      if (rst) begin
        have_hold = 1'b0;
      end else begin
        cur = {out_addr, out_data, out_last, out_sum_w};
        if (out_valid && have_hold) check("stall_hold", 32'(cur), 32'(held));
        if (out_valid && out_ready) begin
          beats++;
          if (exp_q.size() == 0) begin
            check("beat_unexpected", 32'(cur), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("beat", 32'(cur), 32'(e));
          end
          have_hold = 1'b0;
        end else if (out_valid) begin
          held = cur;
          have_hold = 1'b1;
        end else begin
          have_hold = 1'b0;
        end
        if (done) done_cnt++;
      end
    end
  endtask

  // 0: always ready; 1: 0,0,1 per beat; 2: random; 4: stall on addr 3
  task automatic ready_driver();
    int stall_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        1: begin
          if (out_valid) begin
            out_ready = (stall_cnt == 2);
            stall_cnt = (stall_cnt == 2) ? 0 : stall_cnt + 1;
          end else begin
            out_ready = 1'b0;
            stall_cnt = 0;
          end
        end
        2: out_ready = 1'($urandom_range(0, 1));
        4: out_ready = !(out_valid && out_addr == 3);
        default: out_ready = 1'b1;
      endcase
    end
  endtask

  // Returns at the negedge of the cycle after the start edge in which done
  // is seen; n counts cycles with the READ cycle as 1. n = -1 on timeout.
  task automatic wait_done(input int max, output int n);
    n = -1;
    for (int k = 1; k <= max; k++) begin
      @(negedge clk);
      if (done) begin
        n = k;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    push_snapshot();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {busy, done, out_valid, out_last, out_sum_w, 8'(out_addr), 8'(rf_read_addr), out_data},
          32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int d0, b0;
    fork
      monitor();
      ready_driver();
    join_none

    for (int i = 0; i < NUM_REGS; i++) rf[i] = DATA_W'(16'h1111 * i);
    idle(3);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    idle(2);
    check_reset_outputs("idle_state");

    // Directed walk with out_ready held high: fixed latency.
    ready_mode = 0;
    pulse_start();
    wait_done(100, n);
    check("done_cycle", 32'(n), 32'(DONE_CYC));
    @(posedge clk);
    #1;
    check("busy_after_done", 32'(busy), 32'h0);
    check("rf_addr_idle", 32'(rf_read_addr), 32'h0);
    check("queue_empty_t1", 32'(exp_q.size()), 32'h0);

    // Stalled sink: 0,0,1 per beat.
    ready_mode = 1;
    idle(2);
    pulse_start();
    wait_done(300, n);
    check("done_seen_stall", 32'(n > 0), 32'h1);
    idle(2);
    check("queue_empty_t2", 32'(exp_q.size()), 32'h0);

    // start re-asserted at cycle 5 must be ignored.
    ready_mode = 0;
    for (int i = 1; i < NUM_REGS; i++) rf[i] = DATA_W'($urandom);
    idle(2);
    d0 = done_cnt;
    b0 = beats;
    pulse_start();
    idle(4);
    start = 1'b1;
    idle(1);
    start = 1'b0;
    idle(40);
    check("single_done", 32'(done_cnt - d0), 32'h1);
    check("beat_count", 32'(beats - b0), 32'(NUM_REGS + CSUM));
    check("queue_empty_t3", 32'(exp_q.size()), 32'h0);

    // Reset while SEND of addr 3 is stalled.
    ready_mode = 4;
    idle(2);
    pulse_start();
    n = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_valid && out_addr == 3) begin
        n = k;
        break;
      end
    end
    check("reached_addr3", 32'(n >= 0), 32'h1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    d0 = done_cnt;
    #1;
    check_reset_outputs("mid_reset_outputs");
    idle(2);
    rst = 1'b0;
    idle(5);
    check("no_done_after_reset", 32'(done_cnt - d0), 32'h0);
    check("idle_after_reset", 32'(busy), 32'h0);
    ready_mode = 0;
    pulse_start();
    wait_done(100, n);
    check("done_cycle_after_reset", 32'(n), 32'(DONE_CYC));

    // Held start: one idle cycle between snapshots.
    idle(2);
    start = 1'b1;
    push_snapshot();
    push_snapshot();
    idle(1);
    wait_done(100, n);
    check("done_cycle_held", 32'(n), 32'(DONE_CYC));
    @(posedge clk);
    #1;
    check("idle_gap", 32'(busy), 32'h0);
    @(posedge clk);
    #1;
    check("restart_busy", 32'(busy), 32'h1);
    start = 1'b0;
    wait_done(100, n);
    check("done_seen_held", 32'(n > 0), 32'h1);
    idle(2);
    check("queue_empty_t5", 32'(exp_q.size()), 32'h0);

    // All-ones registers: checksum wraps (0xFFF9 with the checksum beat).
    for (int i = 1; i < NUM_REGS; i++) rf[i] = '1;
    pulse_start();
    wait_done(100, n);
    check("done_cycle_ones", 32'(n), 32'(DONE_CYC));
    idle(2);

    // Randomized data with random back-pressure.
    ready_mode = 2;
    for (int t = 0; t < 5; t++) begin
      for (int i = 1; i < NUM_REGS; i++) rf[i] = DATA_W'($urandom);
      idle(int'($urandom_range(1, 4)));
      pulse_start();
      wait_done(400, n);
      check("done_seen_rand", 32'(n > 0), 32'h1);
    end
    idle(3);
    check("queue_empty_final", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_snapshot.md
# regfile_snapshot

Debug snapshot reader for the unicycle core's 8x16 register file. On a start request it walks register addresses 0 through NUM_REGS-1 over one register-file read port, capturing each value and streaming it out as an address/data beat over a valid/ready handshake. It sits beside the decode stage and takes over a read port while the core is halted, so a debug host can dump architectural state.

## Interface
- DATA_W, 16, register width
- ADDR_W, 3, register address width
- NUM_REGS, 8, registers walked; must be ≤ 2^ADDR_W
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  level; sampled only in IDLE
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse after the final beat is accepted
- rf_read_addr  output  ADDR_W  drives the register-file read address
- rf_read_data  input  DATA_W  combinational read data returned for rf_read_addr
- out_valid  output  1  beat available
- out_ready  input  1  sink accepts the beat
- out_data  output  DATA_W  registered captured value
- out_addr  output  ADDR_W  register index of the current beat
- out_last  output  1  high on the final beat of a snapshot
- out_sum  output  1  exists only with SNAPSHOT_CHECKSUM_EN; marks the checksum beat

## Operation
- The FSM has four states: IDLE, READ, SEND and DONE. It holds an index counter idx (ADDR_W bits).
- IDLE: if start=1, then idx←0 and the FSM goes to READ. Otherwise it stays in IDLE.
- READ: rf_read_addr=idx. At the clock edge, out_data←rf_read_data, out_addr←idx, and the FSM goes to SEND.
- SEND: out_valid=1. The FSM holds until out_valid&&out_ready.
  - On the handshake, if idx==NUM_REGS-1, the FSM goes to DONE.
  - Otherwise idx←idx+1 and the FSM goes to READ.
- DONE: done=1 for exactly one cycle, then the FSM goes to IDLE. If start is still high, a new snapshot begins on the next IDLE cycle (start is not edge-detected).
- Register 0 is read like any other register. The register file returns 0 for it, and that value is emitted.
- out_last=1 in SEND when idx==NUM_REGS-1 and no checksum beat follows.
- start is ignored while busy.
- rf_read_addr=idx in all states. It is 0 at reset and in IDLE.
- idx never wraps: the terminal compare ends the walk at NUM_REGS-1.

## Timing
- Reset values of the outputs:
  - busy=0, done=0, out_valid=0, out_last=0, out_sum=0
  - out_data=0, out_addr=0, rf_read_addr=0
  - state=IDLE
- Reset asserted mid-snapshot aborts the snapshot immediately. No done pulse is produced. After reset releases, the FSM waits in IDLE.
- Latency: start sampled in cycle 0 gives READ in cycle 1 and the first out_valid in cycle 2.
- Each beat costs one READ cycle plus at least one SEND cycle.
- With out_ready held at 1, a full snapshot is start + 2×NUM_REGS + DONE = 18 cycles. done is high in cycle 17.
- out_data, out_addr, out_last and out_sum are stable while out_valid=1 and out_ready=0.
- out_valid is deasserted in READ. Back-to-back beats are therefore never emitted.
- rf_read_data is assumed stable in the READ cycle. The core must not write the register file while busy=1; the block does not check this.

## Configuration
- SNAPSHOT_CHECKSUM_EN defined:
  - A DATA_W accumulator sum is cleared on leaving IDLE.
  - It adds each captured value modulo 2^DATA_W on each READ edge.
  - After register NUM_REGS-1 is accepted, one extra beat follows before DONE:
    - out_data=sum, out_addr=0
    - out_sum=1, out_last=1
  - The register beats have out_last=0.
  - Full-snapshot cycle count with out_ready=1 is 20.
- SNAPSHOT_CHECKSUM_EN undefined:
  - There is no accumulator and no out_sum port.
  - out_last is set on register NUM_REGS-1.

## Test plan
- Preload r1..r7=0x1111×i. Pulse start for 1 cycle with out_ready=1. Required response:
  - Beats (addr,data): (0,0x0000), (1,0x1111) … (7,0x7777).
  - out_last only on addr 7.
  - done in cycle 17; busy low in cycle 18.
- Same preload with out_ready toggling 0,0,1 per beat. Required response:
  - Data/addr hold while stalled.
  - The same 8 beats arrive in order with no duplicates or drops.
- Assert start again while busy, at cycle 5. Required response: no restart; exactly 8 beats; a single done pulse.
- Assert rst during SEND of addr 3. Required response:
  - All outputs are at their reset values within the same cycle.
  - No done pulse.
  - A following start produces a fresh walk from addr 0.
- Hold start high continuously. Required response: after the done pulse, one IDLE cycle, then a new snapshot starting at addr 0.
- With SNAPSHOT_CHECKSUM_EN and r1..r7=0xFFFF, required response:
  - A ninth beat carries out_data=0xFFF9 with out_sum=1 and out_last=1.
  - done in cycle 19.
